port_rd_frontend: RTL and testbench

- Consumer end of the per-port read scheduler. This block owns per-queue packet occupancy and drives `queue_empty[3:0]` into the scheduler.
- It samples the scheduler's `prior_next`, fetches the selected queue's packet word by word from the packet store, and streams it out with valid/ready.
- It pulses `prior_update` once per dequeued packet, and sits between the packet store and the egress port MAC.

---
 rtl/port_rd_frontend_pkg.sv | 9 +
 rtl/port_rd_obuf.sv | 44 ++++
 rtl/port_rd_frontend.sv | 166 ++++++++++++++++
 tb/tb_port_rd_frontend.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/port_rd_frontend_pkg.sv
// Shared constants and types for the per-port read frontend.
package port_rd_frontend_pkg;
    localparam int NUM_QUEUES = 4;
    localparam int QUEUE_W = $clog2(NUM_QUEUES);
    localparam logic [2:0] PRIOR_NONE = 3'd4;
    localparam int HDR_LEN_LSB = 0;

    typedef enum logic [1:0] {IDLE, HEAD_WAIT, BODY} fe_state_t;
endpackage

// File: rtl/port_rd_obuf.sv
// Output word buffer between packet-store returns and the egress port.
// Latency: a word pushed in cycle T is visible on pop_dat in T+1.
// Backpressure: pop_rdy stalls the head; push is never refused because the caller's credit check bounds occupancy.
module port_rd_obuf #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
)(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_vld,
    input  logic [WIDTH-1:0]           push_dat,
    output logic                       pop_vld,
    input  logic                       pop_rdy,
    output logic [WIDTH-1:0]           pop_dat,
    output logic [$clog2(DEPTH+1)-1:0] occ
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop;

    assign pop_vld = (occ != '0);
    assign pop     = pop_vld && pop_rdy;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + 1'b1;
            if (pop)      rd_ptr <= rd_ptr + 1'b1;
            if (push_vld && !pop)      occ <= occ + 1'b1;
            else if (!push_vld && pop) occ <= occ - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_vld) mem[wr_ptr] <= push_dat;
    end
endmodule

// File: rtl/port_rd_frontend.sv
// Per-port read frontend: tracks queue occupancy, fetches the scheduler's chosen packet, streams it out.
// Latency: header rd_req in T reaches port_data at T+RD_LATENCY+1 at the earliest.
// Backpressure: port_ready stalls the output buffer; reads are issued only while in-flight + buffered < BUF_DEPTH.
module port_rd_frontend
    import port_rd_frontend_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int LEN_WIDTH     = 11,
    parameter int CNT_WIDTH     = 8,
    parameter int RD_LATENCY    = 2,
    parameter int BUF_DEPTH     = 4,
    parameter int SETTLE_CYCLES = 6
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enq_valid,
    input  logic [QUEUE_W-1:0]    enq_queue,
    output logic [NUM_QUEUES-1:0] queue_empty,
    input  logic [2:0]            prior_next,
    output logic                  prior_update,
    output logic                  rd_req,
    output logic [QUEUE_W-1:0]    rd_queue,
    input  logic                  rd_valid,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  port_valid,
    input  logic                  port_ready,
    output logic [DATA_WIDTH-1:0] port_data,
    output logic                  port_sop,
    output logic                  port_eop,
    output logic                  err_overflow
);
    // inflight is bounded by credit; width also covers a full read pipeline
    localparam int IF_MAX = (BUF_DEPTH > RD_LATENCY) ? BUF_DEPTH : RD_LATENCY;
    localparam int IW     = $clog2(IF_MAX + 1);
    localparam int OW     = $clog2(BUF_DEPTH + 1);
    localparam int SW     = $clog2(SETTLE_CYCLES + 1);

    fe_state_t             state, state_nxt;
    logic [CNT_WIDTH-1:0]  cnt [NUM_QUEUES];
    logic [NUM_QUEUES-1:0] inc, dec;
    logic [QUEUE_W-1:0]    cur_queue, cur_queue_nxt;
    logic [LEN_WIDTH-1:0]  remaining, remaining_nxt, ret_left, hdr_len;
    logic [SW-1:0]         settle;
    logic [IW-1:0]         inflight, used;
    logic [OW-1:0]         occ;
    logic                  credit, rd_hit, ret_sop, ret_eop;
    logic [DATA_WIDTH+1:0] ob_dat;

    always_comb begin
        for (int q = 0; q < NUM_QUEUES; q++) begin
            inc[q]         = enq_valid && (enq_queue == QUEUE_W'(q));
            dec[q]         = prior_update && (cur_queue == QUEUE_W'(q));
            queue_empty[q] = (cnt[q] == '0);
        end
    end

    always_comb begin
        hdr_len = rd_data[HDR_LEN_LSB +: LEN_WIDTH];
        if (hdr_len == '0) hdr_len = LEN_WIDTH'(1);
    end

    assign used   = inflight + IW'(occ);
    assign credit = (used < IW'(BUF_DEPTH));
    // returns arriving with nothing outstanding are leftovers from before a reset
    assign rd_hit = rd_valid && (inflight != '0);

    // Headers are only issued with nothing outstanding, so any return seen in HEAD_WAIT is the header.
    assign ret_sop = (state == HEAD_WAIT);
    assign ret_eop = ret_sop ? (hdr_len == LEN_WIDTH'(1)) : (ret_left == LEN_WIDTH'(1));

    always_comb begin
        state_nxt     = state;
        cur_queue_nxt = cur_queue;
        remaining_nxt = remaining;
        rd_req        = 1'b0;
        rd_queue      = cur_queue;
        prior_update  = 1'b0;
        case (state)
            IDLE: begin
                if (settle == '0 && prior_next < PRIOR_NONE && !queue_empty[prior_next[QUEUE_W-1:0]]
                    && credit && inflight == '0) begin
                    rd_req        = 1'b1;
                    rd_queue      = prior_next[QUEUE_W-1:0];
                    cur_queue_nxt = prior_next[QUEUE_W-1:0];
                    state_nxt     = HEAD_WAIT;
                end
            end
            HEAD_WAIT: begin
                if (rd_hit) begin
                    remaining_nxt = hdr_len - 1'b1;
                    if (hdr_len == LEN_WIDTH'(1)) begin
                        prior_update = 1'b1;
                        state_nxt    = IDLE;
                    end else begin
                        state_nxt    = BODY;
                    end
                end
            end
            BODY: begin
                if (credit && remaining != '0) begin
                    rd_req        = 1'b1;
                    remaining_nxt = remaining - 1'b1;
                    if (remaining == LEN_WIDTH'(1)) begin
                        prior_update = 1'b1;
                        state_nxt    = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cur_queue <= '0;
            remaining <= '0;
            ret_left  <= '0;
            settle    <= '0;
            inflight  <= '0;
        end else begin
            state     <= state_nxt;
            cur_queue <= cur_queue_nxt;
            remaining <= remaining_nxt;
            if (rd_hit) ret_left <= ret_sop ? hdr_len - 1'b1 : ret_left - 1'b1;
            if (prior_update)       settle <= SW'(SETTLE_CYCLES);
            else if (settle != '0)  settle <= settle - 1'b1;
            if (rd_req && !rd_hit)      inflight <= inflight + 1'b1;
            else if (!rd_req && rd_hit) inflight <= inflight - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int q = 0; q < NUM_QUEUES; q++) cnt[q] <= '0;
            err_overflow <= 1'b0;
        end else begin
            for (int q = 0; q < NUM_QUEUES; q++) begin
                if (inc[q] && !dec[q]) begin
                    if (&cnt[q]) err_overflow <= 1'b1;
                    else         cnt[q] <= cnt[q] + 1'b1;
                end else if (dec[q] && !inc[q]) begin
                    cnt[q] <= cnt[q] - 1'b1;
                end
            end
        end
    end

    port_rd_obuf #(
        .WIDTH (DATA_WIDTH + 2),
        .DEPTH (BUF_DEPTH)
    ) u_obuf (
        .clk      (clk),
        .rst      (rst),
        .push_vld (rd_hit),
        .push_dat ({rd_data, ret_sop, ret_eop}),
        .pop_vld  (port_valid),
        .pop_rdy  (port_ready),
        .pop_dat  (ob_dat),
        .occ      (occ)
    );

    assign port_data = ob_dat[DATA_WIDTH+1:2];
    assign port_sop  = port_valid & ob_dat[1];
    assign port_eop  = port_valid & ob_dat[0];
endmodule

// File: tb/tb_port_rd_frontend.sv
// Directed bench for port_rd_frontend with a fixed-latency packet-store model and output scoreboard.
module tb_port_rd_frontend;
    logic        clk = 1'b0;
    logic        rst;
    logic        enq_valid;
    logic [1:0]  enq_queue;
    logic [3:0]  queue_empty;
    logic [2:0]  prior_next;
    logic        prior_update;
    logic        rd_req;
    logic [1:0]  rd_queue;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        port_valid;
    logic        port_ready;
    logic [15:0] port_data;
    logic        port_sop;
    logic        port_eop;
    logic        err_overflow;

    always #5 clk = ~clk;

    port_rd_frontend dut (
        .clk          (clk),
        .rst          (rst),
        .enq_valid    (enq_valid),
        .enq_queue    (enq_queue),
        .queue_empty  (queue_empty),
        .prior_next   (prior_next),
        .prior_update (prior_update),
        .rd_req       (rd_req),
        .rd_queue     (rd_queue),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .port_valid   (port_valid),
        .port_ready   (port_ready),
        .port_data    (port_data),
        .port_sop     (port_sop),
        .port_eop     (port_eop),
        .err_overflow (err_overflow)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_req, n_pu, n_extra, last_req_cyc, last_pu_cyc, first_req_cyc, first_pv_cyc, p_cyc;
    logic [1:0]  exp_rq = 2'd0;
    bit          store_en = 1'b1;
    logic        p0_vld = 1'b0;
    logic [15:0] p0_dat = 16'h0;
    logic [15:0] st_q [4][$];
    logic [17:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: observe outputs at the falling edge, then advance the store pipeline after the rising edge.
    task automatic tick();
        logic       req_now;
        logic [1:0] q_now;
        @(negedge clk);
        req_now = rd_req;
        q_now   = rd_queue;
        if (rd_req) begin
            n_req++;
            last_req_cyc = cyc;
            if (first_req_cyc < 0) first_req_cyc = cyc;
            chk("rd_queue", {30'd0, rd_queue}, {30'd0, exp_rq});
        end
        if (prior_update) begin
            n_pu++;
            last_pu_cyc = cyc;
        end
        if (port_valid && first_pv_cyc < 0) first_pv_cyc = cyc;
        if (port_valid && port_ready) begin
            if (exp_q.size() == 0) n_extra++;
            else chk("out_word", {14'd0, port_data, port_sop, port_eop}, {14'd0, exp_q.pop_front()});
        end
        @(posedge clk);
        #1;
        cyc++;
        if (store_en) begin
            rd_valid = p0_vld;
            rd_data  = p0_dat;
            p0_vld   = req_now;
            if (req_now) begin
                if (st_q[q_now].size() != 0) p0_dat = st_q[q_now].pop_front();
                else                         p0_dat = 16'hDEAD;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clr();
        n_req = 0; n_pu = 0; n_extra = 0;
        first_req_cyc = -1; first_pv_cyc = -1;
    endtask

    task automatic ld(input int q, input logic [15:0] d);
        st_q[q].push_back(d);
    endtask

    task automatic push_exp(input logic [15:0] d, input logic s, input logic e);
        exp_q.push_back({d, s, e});
    endtask

    task automatic enq(input logic [1:0] q);
        enq_valid = 1'b1;
        enq_queue = q;
        tick();
        enq_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; enq_valid = 1'b0; enq_queue = 2'd0; prior_next = 3'd4;
        rd_valid = 1'b0; rd_data = 16'h0; port_ready = 1'b0;
        clr();
        run(3);
        chk("rst_qempty", {28'd0, queue_empty}, 32'hF);
        chk("rst_rd_req", {31'd0, rd_req}, 32'd0);
        chk("rst_pu", {31'd0, prior_update}, 32'd0);
        chk("rst_pvalid", {31'd0, port_valid}, 32'd0);
        chk("rst_sop", {31'd0, port_sop}, 32'd0);
        chk("rst_eop", {31'd0, port_eop}, 32'd0);
        chk("rst_err", {31'd0, err_overflow}, 32'd0);
        rst = 1'b0;
        run(2);

        // len=3 packet from q2
        clr(); port_ready = 1'b1; prior_next = 3'd2; exp_rq = 2'd2;
        ld(2, 16'h0003); ld(2, 16'h2001); ld(2, 16'h2002);
        push_exp(16'h0003, 1'b1, 1'b0); push_exp(16'h2001, 1'b0, 1'b0); push_exp(16'h2002, 1'b0, 1'b1);
        chk("t1_qe_before", {28'd0, queue_empty}, 32'hF);
        enq(2'd2);
        chk("t1_qe_after_enq", {28'd0, queue_empty}, 32'hB);
        run(20);
        chk("t1_nreq", n_req, 3);
        chk("t1_npu", n_pu, 1);
        chk("t1_latency", first_pv_cyc - first_req_cyc, 3);
        chk("t1_qe_end", {28'd0, queue_empty}, 32'hF);
        chk("t1_left", exp_q.size(), 0);
        chk("t1_extra", n_extra, 0);

        // len=1 and len=0 single-word packets from q1
        clr(); prior_next = 3'd1; exp_rq = 2'd1;
        ld(1, 16'h0001); push_exp(16'h0001, 1'b1, 1'b1);
        enq(2'd1);
        run(12);
        chk("t2a_nreq", n_req, 1);
        chk("t2a_npu", n_pu, 1);
        chk("t2a_pu_cyc", last_pu_cyc - last_req_cyc, 2);
        chk("t2a_left", exp_q.size(), 0);
        clr();
        ld(1, 16'hF800); push_exp(16'hF800, 1'b1, 1'b1);
        enq(2'd1);
        run(12);
        chk("t2b_nreq", n_req, 1);
        chk("t2b_npu", n_pu, 1);
        chk("t2b_pu_cyc", last_pu_cyc - last_req_cyc, 2);
        chk("t2b_left", exp_q.size(), 0);
        chk("t2b_extra", n_extra, 0);

        // len=10 with the port stalled: credit caps reads at 4
        clr(); port_ready = 1'b0; prior_next = 3'd0; exp_rq = 2'd0;
        ld(0, 16'h500A); push_exp(16'h500A, 1'b1, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            ld(0, 16'h5000 + 16'(i));
            push_exp(16'h5000 + 16'(i), 1'b0, (i == 9));
        end
        enq(2'd0);
        run(20);
        chk("t3_nreq_stalled", n_req, 4);
        chk("t3_pvalid", {31'd0, port_valid}, 32'd1);
        chk("t3_head_data", {16'd0, port_data}, 32'h500A);
        chk("t3_head_sop", {31'd0, port_sop}, 32'd1);
        port_ready = 1'b1;
        run(30);
        chk("t3_nreq", n_req, 10);
        chk("t3_npu", n_pu, 1);
        chk("t3_left", exp_q.size(), 0);
        chk("t3_extra", n_extra, 0);
        chk("t3_qe_end", {28'd0, queue_empty}, 32'hF);

        // prior_next=4 holds off reads; settle window after prior_update
        clr(); prior_next = 3'd4;
        ld(3, 16'h3001); ld(2, 16'h2801);
        push_exp(16'h3001, 1'b1, 1'b1); push_exp(16'h2801, 1'b1, 1'b1);
        enq(2'd3); enq(2'd2);
        run(3);
        chk("t6_qe", {28'd0, queue_empty}, 32'h3);
        chk("t6_none_nreq", n_req, 0);
        prior_next = 3'd3; exp_rq = 2'd3;
        for (int i = 0; i < 20 && n_pu == 0; i++) tick();
        chk("t6_pu_seen", n_pu, 1);
        p_cyc = last_pu_cyc;
        prior_next = 3'd2; exp_rq = 2'd2; first_req_cyc = -1;
        run(15);
        chk("t6_settle_cyc", first_req_cyc - p_cyc, 7);
        chk("t6_npu", n_pu, 2);
        chk("t6_left", exp_q.size(), 0);
        run(8);

        // same-cycle enqueue and dequeue on q0 with count 1
        clr(); prior_next = 3'd0; exp_rq = 2'd0;
        ld(0, 16'hF801); ld(0, 16'h7801);
        push_exp(16'hF801, 1'b1, 1'b1); push_exp(16'h7801, 1'b1, 1'b1);
        enq(2'd0);
        tick(); tick();
        enq_valid = 1'b1; enq_queue = 2'd0;
        tick();
        enq_valid = 1'b0;
        chk("t4_pu_align", last_pu_cyc - last_req_cyc, 2);
        chk("t4_qe_kept", {28'd0, queue_empty}, 32'hE);
        run(20);
        chk("t4_nreq", n_req, 2);
        chk("t4_npu", n_pu, 2);
        chk("t4_qe_end", {28'd0, queue_empty}, 32'hF);
        chk("t4_left", exp_q.size(), 0);

        // saturate q1 counter
        clr(); prior_next = 3'd4;
        enq_valid = 1'b1; enq_queue = 2'd1;
        run(255);
        chk("t5_err_at_255", {31'd0, err_overflow}, 32'd0);
        tick();
        enq_valid = 1'b0;
        chk("t5_err_at_256", {31'd0, err_overflow}, 32'd1);
        run(3);
        chk("t5_err_sticky", {31'd0, err_overflow}, 32'd1);
        chk("t5_nreq", n_req, 0);
        chk("t5_qe", {28'd0, queue_empty}, 32'hD);

        // reset mid-BODY with two body reads outstanding; store driven by hand
        store_en = 1'b0; rd_valid = 1'b0;
        clr(); port_ready = 1'b0; prior_next = 3'd3; exp_rq = 2'd3;
        enq(2'd3);
        tick();
        rd_valid = 1'b1; rd_data = 16'h0008;
        tick();
        rd_valid = 1'b0;
        tick(); tick();
        chk("t7_nreq_pre", n_req, 3);
        chk("t7_pvalid_pre", {31'd0, port_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("t7_rd_req", {31'd0, rd_req}, 32'd0);
        chk("t7_pvalid", {31'd0, port_valid}, 32'd0);
        chk("t7_sop", {31'd0, port_sop}, 32'd0);
        chk("t7_eop", {31'd0, port_eop}, 32'd0);
        chk("t7_pu", {31'd0, prior_update}, 32'd0);
        chk("t7_qe", {28'd0, queue_empty}, 32'hF);
        chk("t7_err", {31'd0, err_overflow}, 32'd0);
        tick();
        rst = 1'b0;
        clr(); port_ready = 1'b1;
        rd_valid = 1'b1; rd_data = 16'hBAD0;
        tick(); tick();
        rd_valid = 1'b0;
        run(4);
        chk("t7_stale_pvalid", {31'd0, port_valid}, 32'd0);
        chk("t7_stale_seen", {31'd0, (first_pv_cyc < 0)}, 32'd1);
        chk("t7_stale_extra", n_extra, 0);
        chk("t7_stale_nreq", n_req, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
